// File: rtl/norm_shift_32.sv
// Iterative left-normalizer: counts leading zeros (unsigned) or redundant sign bits (signed)
// and returns the operand shifted so the leading significant bit sits at the MSB.
// Optional build macro NORM_COARSE_STEP_EN enables STEP-bit coarse shifts per cycle.
module norm_shift_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1,
  parameter int STEP  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  // Elaboration-time guard on the shift geometry.
  if (STEP <= 1 || STEP >= WIDTH || WIDTH < 16 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_cfg
    $error("norm_shift_32: illegal WIDTH/STEP combination");
  end

  state_e           state_q;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             signed_q;
  logic             zero_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             done_now;
  logic             coarse_ok;

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    done_now  = signed_q ? (work_q[WIDTH-1] ^ work_q[WIDTH-2]) : work_q[WIDTH-1];
    coarse_ok = 1'b0;
`ifdef NORM_COARSE_STEP_EN
    // Signed mode needs STEP+1 equal bits so the sign survives the coarse shift.
    if (signed_q)
      coarse_ok = (&work_q[WIDTH-1 -: STEP+1]) || !(|work_q[WIDTH-1 -: STEP+1]);
    else
      coarse_ok = !(|work_q[WIDTH-1 -: STEP]);
`endif
    work_d  = work_q << 1;
    count_d = count_q + CNT_W'(1);
    if (coarse_ok) begin
      work_d  = work_q << STEP;
      count_d = count_q + CNT_W'(STEP);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      count_q     <= '0;
      signed_q    <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            work_q     <= in_data;
            signed_q   <= in_signed;
            in_ready_q <= 1'b0;
            if (in_data == '0) begin
              count_q     <= CNT_W'(WIDTH);
              zero_q      <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              count_q <= '0;
              zero_q  <= 1'b0;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (done_now) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            work_q  <= work_d;
            count_q <= count_d;
          end
        end
        DONE: begin
          // in_ready rises only after the handoff edge, never on it.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = work_q;
  assign out_count = count_q;
  assign out_zero  = zero_q;

endmodule
